alarma_programable: RTL and testbench

Multi-channel programmable alarm controller for the digital clock. It holds `N_ALARMS` independently writable alarm times and detects when the running time first matches each one. Each triggered channel rings for a bounded period, with snooze (`posponer`) and stop (`apagar`) controls and a blinking LED output. It sits between the time-keeping counters (`minutos`, `horas`, 1 Hz `tick`) and the board LEDs/buzzer.

---
 rtl/alarma_programable.sv | 179 +++++++++++++++++
 tb/tb_alarma_programable.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alarma_programable.sv
// alarma_programable: multi-channel programmable alarm controller.
// Each channel stores an alarm time, detects the first cycle the running
// time equals it, then rings for a bounded number of ticks. Snooze and stop
// inputs act on all channels at once. The LED output blinks while any
// channel is ringing.
module alarma_programable #(
  parameter int N_ALARMS   = 4,
  parameter int MIN_W      = 7,
  parameter int HOUR_W     = 5,
  parameter int LED_W      = 4,
  parameter int RING_SEC   = 60,
  parameter int SNOOZE_SEC = 300,
  parameter int MAX_SNOOZE = 3,
  localparam int SEL_W     = (N_ALARMS > 1) ? $clog2(N_ALARMS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                tick,
  input  logic [MIN_W-1:0]    minutos,
  input  logic [HOUR_W-1:0]   horas,
  input  logic                wr_en,
  input  logic [SEL_W-1:0]    wr_sel,
  input  logic [MIN_W-1:0]    wr_minutos,
  input  logic [HOUR_W-1:0]   wr_horas,
  input  logic                wr_habil,
  input  logic                posponer,
  input  logic                apagar,
  output logic [N_ALARMS-1:0] sonando,
  output logic [N_ALARMS-1:0] pospuesto,
  output logic                alarma,
  output logic [LED_W-1:0]    ledsAl
);

  // One counter serves both the ring and the snooze period, so it must hold
  // the longer of the two.
  localparam int CNT_MAX = (RING_SEC > SNOOZE_SEC) ? RING_SEC : SNOOZE_SEC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int NSNZ_W  = (MAX_SNOOZE > 0) ? $clog2(MAX_SNOOZE + 1) : 1;

  // Counter value at which the next tick ends the period.
  localparam logic [CNT_W-1:0]  RING_LAST   = CNT_W'(RING_SEC - 1);
  localparam logic [CNT_W-1:0]  SNOOZE_LAST = CNT_W'(SNOOZE_SEC - 1);
  localparam logic [NSNZ_W-1:0] NSNZ_MAX    = NSNZ_W'(MAX_SNOOZE);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RING   = 2'd1,
    ST_SNOOZE = 2'd2
  } state_t;

  // The running time is registered once so that every channel compares
  // against the same stable value; a new time therefore triggers one cycle
  // after it is first sampled.
  logic [MIN_W-1:0]  minutos_reg;
  logic [HOUR_W-1:0] horas_reg;
  logic              fase_reg;

  // Capture the running time.
  always_ff @(posedge clk) begin
    if (reset) begin
      minutos_reg <= '0;
      horas_reg   <= '0;
    end else begin
      minutos_reg <= minutos;
      horas_reg   <= horas;
    end
  end

  for (genvar gi = 0; gi < N_ALARMS; gi++) begin : g_ch
    logic [MIN_W-1:0]  min_reg;
    logic [HOUR_W-1:0] hr_reg;
    logic              hab_reg;
    logic              match_prev_reg;
    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [NSNZ_W-1:0] nsnz_reg, nsnz_next;
    logic              sel;
    logic              match;
    logic              trigger;

    assign sel     = wr_en && (wr_sel == SEL_W'(gi));
    assign match   = hab_reg && (minutos_reg == min_reg) && (horas_reg == hr_reg);
    // Only the first cycle of a match rings, so a held match or a match that
    // was just stopped does not ring again within the same minute.
    assign trigger = match && !match_prev_reg;

    // Next state, in descending priority: stop, disabling write, snooze,
    // tick expiry / counting, trigger.
    always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      nsnz_next  = nsnz_reg;
      if (apagar) begin
        state_next = ST_IDLE;
        cnt_next   = '0;
      end else if (sel && !wr_habil) begin
        state_next = ST_IDLE;
        cnt_next   = '0;
      end else begin
        case (state_reg)
          ST_RING: begin
            if (posponer && (nsnz_reg < NSNZ_MAX)) begin
              state_next = ST_SNOOZE;
              cnt_next   = '0;
              nsnz_next  = nsnz_reg + NSNZ_W'(1);
            end else if (tick) begin
              if (cnt_reg == RING_LAST) begin
                state_next = ST_IDLE;
                cnt_next   = '0;
              end else begin
                cnt_next = cnt_reg + CNT_W'(1);
              end
            end
          end
          ST_SNOOZE: begin
            if (tick) begin
              if (cnt_reg == SNOOZE_LAST) begin
                state_next = ST_RING;
                cnt_next   = '0;
              end else begin
                cnt_next = cnt_reg + CNT_W'(1);
              end
            end
          end
          default: begin
            if (trigger) begin
              state_next = ST_RING;
              cnt_next   = '0;
              nsnz_next  = '0;
            end
          end
        endcase
      end
    end

    // Channel registers: state, counters, match history and stored alarm.
    always_ff @(posedge clk) begin
      if (reset) begin
        state_reg      <= ST_IDLE;
        cnt_reg        <= '0;
        nsnz_reg       <= '0;
        match_prev_reg <= 1'b0;
        min_reg        <= '0;
        hr_reg         <= '0;
        hab_reg        <= 1'b0;
      end else begin
        state_reg      <= state_next;
        cnt_reg        <= cnt_next;
        nsnz_reg       <= nsnz_next;
        match_prev_reg <= match;
        if (sel) begin
          min_reg <= wr_minutos;
          hr_reg  <= wr_horas;
          hab_reg <= wr_habil;
        end
      end
    end

    assign sonando[gi]   = (state_reg == ST_RING);
    assign pospuesto[gi] = (state_reg == ST_SNOOZE);
  end

  assign alarma = |sonando;

  // Blink phase: parked at 1 while silent so the LEDs light immediately on a
  // new ring, then toggled once per second.
  always_ff @(posedge clk) begin
    if (reset) begin
      fase_reg <= 1'b1;
    end else if (!alarma) begin
      fase_reg <= 1'b1;
    end else if (tick) begin
      fase_reg <= ~fase_reg;
    end
  end

  assign ledsAl = {LED_W{alarma & fase_reg}};

endmodule

// File: tb/tb_alarma_programable.sv
// Testbench for alarma_programable: directed scenarios, a countdown-based
// behavioural model compared every cycle, plus literal spot checks.
module tb_alarma_programable;

  localparam int N    = 4;
  localparam int RING = 60;
  localparam int SNZ  = 300;
  localparam int MAXS = 3;

  logic       clk = 1'b0;
  logic       reset, tick, wr_en, wr_habil, posponer, apagar;
  logic [6:0] minutos, wr_minutos;
  logic [4:0] horas, wr_horas;
  logic [1:0] wr_sel;
  logic [3:0] sonando, pospuesto, ledsAl;
  logic       alarma;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  alarma_programable dut (
    .clk        (clk),
    .reset      (reset),
    .tick       (tick),
    .minutos    (minutos),
    .horas      (horas),
    .wr_en      (wr_en),
    .wr_sel     (wr_sel),
    .wr_minutos (wr_minutos),
    .wr_horas   (wr_horas),
    .wr_habil   (wr_habil),
    .posponer   (posponer),
    .apagar     (apagar),
    .sonando    (sonando),
    .pospuesto  (pospuesto),
    .alarma     (alarma),
    .ledsAl     (ledsAl)
  );

  // Behavioural model: mode 0 silent, 1 ringing, 2 snoozed; m_left counts
  // remaining ticks of the current period, m_snz counts remaining snoozes.
  int m_min[N], m_hr[N], m_mode[N], m_left[N], m_snz[N];
  bit m_hab[N], m_prev[N];
  int t_min, t_hr;
  bit m_fase;

  always @(posedge clk) begin
    bit any_ring;
    bit hit;
    bit fresh;
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        m_min[i] = 0; m_hr[i] = 0; m_hab[i] = 0; m_prev[i] = 0;
        m_mode[i] = 0; m_left[i] = 0; m_snz[i] = 0;
      end
      t_min = 0; t_hr = 0; m_fase = 1;
    end else begin
      any_ring = 0;
      for (int i = 0; i < N; i++) if (m_mode[i] == 1) any_ring = 1;
      if (!any_ring) m_fase = 1;
      else if (tick) m_fase = !m_fase;
      for (int i = 0; i < N; i++) begin
        hit   = m_hab[i] && (t_min == m_min[i]) && (t_hr == m_hr[i]);
        fresh = hit && !m_prev[i];
        m_prev[i] = hit;
        if (apagar) m_mode[i] = 0;
        else if (wr_en && int'(wr_sel) == i && !wr_habil) m_mode[i] = 0;
        else if (m_mode[i] == 1 && posponer && m_snz[i] > 0) begin
          m_mode[i] = 2; m_left[i] = SNZ; m_snz[i]--;
        end else if (m_mode[i] == 1 && tick) begin
          m_left[i]--;
          if (m_left[i] == 0) m_mode[i] = 0;
        end else if (m_mode[i] == 2 && tick) begin
          m_left[i]--;
          if (m_left[i] == 0) begin m_mode[i] = 1; m_left[i] = RING; end
        end else if (m_mode[i] == 0 && fresh) begin
          m_mode[i] = 1; m_left[i] = RING; m_snz[i] = MAXS;
        end
        if (wr_en && int'(wr_sel) == i) begin
          m_min[i] = int'(wr_minutos); m_hr[i] = int'(wr_horas); m_hab[i] = wr_habil;
        end
      end
      t_min = int'(minutos);
      t_hr  = int'(horas);
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    logic [3:0] es, ep, el;
    logic ea;
    if (chk_en) begin
      for (int i = 0; i < N; i++) begin
        es[i] = (m_mode[i] == 1);
        ep[i] = (m_mode[i] == 2);
      end
      ea = |es;
      el = (ea && m_fase) ? 4'hF : 4'h0;
      n_vec++;
      if ({sonando, pospuesto, alarma, ledsAl} !== {es, ep, ea, el}) begin
        n_err++;
        $display("FAIL model t=%0t sonando %b want %b pospuesto %b want %b alarma %b want %b ledsAl %b want %b",
                 $time, sonando, es, pospuesto, ep, alarma, ea, ledsAl, el);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_time(input int h, input int m);
    horas   = 5'(h);
    minutos = 7'(m);
    $display("time %02d:%02d", h, m);
  endtask

  task automatic wr(input int ch, input int h, input int m, input bit hab);
    wr_en = 1; wr_sel = 2'(ch); wr_horas = 5'(h); wr_minutos = 7'(m); wr_habil = hab;
    $display("write ch%0d %02d:%02d habil=%0d", ch, h, m, hab);
    cyc(1);
    wr_en = 0;
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      tick = 1; cyc(1);
      tick = 0; cyc(1);
    end
    $display("ticks x%0d", n);
  endtask

  task automatic pulse_pos();
    posponer = 1; cyc(1); posponer = 0;
    $display("posponer");
  endtask

  task automatic pulse_apa();
    apagar = 1; cyc(1); apagar = 0;
    $display("apagar");
  endtask

  initial begin
    reset = 1; tick = 0; wr_en = 0; wr_habil = 0; posponer = 0; apagar = 0;
    minutos = 0; horas = 0; wr_minutos = 0; wr_horas = 0; wr_sel = 0;
    cyc(2);
    chk_en = 1;
    cyc(1);
    check("reset sonando", 32'(sonando), 0);
    check("reset ledsAl", 32'(ledsAl), 0);
    reset = 0;

    // Basic ring, blink and auto-off.
    wr(0, 7, 30, 1);
    set_time(7, 29); cyc(2);
    set_time(7, 30); cyc(1);
    check("s1 latency", 32'(sonando), 32'h0);
    cyc(1);
    check("s1 ring", 32'(sonando), 32'h1);
    check("s1 leds on", 32'(ledsAl), 32'hF);
    ticks(1);
    check("s1 blink off", 32'(ledsAl), 32'h0);
    ticks(1);
    check("s1 blink on", 32'(ledsAl), 32'hF);
    ticks(57);
    check("s1 tick59 ring", 32'(sonando), 32'h1);
    ticks(1);
    check("s1 tick60 off", 32'(sonando), 32'h0);
    check("s1 leds off", 32'(ledsAl), 32'h0);

    // Stop, no retrigger within the minute, ring again next match.
    set_time(7, 59); wr(1, 8, 0, 1); cyc(1);
    set_time(8, 0); cyc(2);
    check("s2 ring", 32'(sonando), 32'h2);
    pulse_apa();
    check("s2 stopped", 32'(sonando), 32'h0);
    cyc(10);
    check("s2 no retrigger", 32'(sonando), 32'h0);
    set_time(8, 1); cyc(2);
    set_time(8, 0); cyc(2);
    check("s2 next day", 32'(sonando), 32'h2);
    pulse_apa();
    set_time(8, 30); cyc(2);

    // Snooze three times, fourth snooze ignored.
    wr(2, 9, 0, 1);
    set_time(8, 59); cyc(2);
    set_time(9, 0); cyc(2);
    check("s3 ring", 32'(sonando), 32'h4);
    for (int k = 0; k < 3; k++) begin
      pulse_pos();
      check("s3 snoozed", 32'(pospuesto), 32'h4);
      check("s3 silent", 32'(sonando), 32'h0);
      ticks(299);
      check("s3 tick299", 32'(pospuesto), 32'h4);
      ticks(1);
      check("s3 ring again", 32'(sonando), 32'h4);
    end
    pulse_pos();
    check("s3 4th posponer ring", 32'(sonando), 32'h4);
    check("s3 4th posponer no snooze", 32'(pospuesto), 32'h0);
    pulse_apa();
    set_time(9, 30); cyc(2);

    // Two channels at the same time.
    wr(0, 10, 15, 1);
    wr(3, 10, 15, 1);
    set_time(10, 14); cyc(2);
    set_time(10, 15); cyc(2);
    check("s4 both ring", 32'(sonando), 32'h9);
    pulse_pos();
    check("s4 both snooze", 32'(pospuesto), 32'h9);
    posponer = 1; apagar = 1; cyc(1); posponer = 0; apagar = 0;
    $display("posponer+apagar");
    check("s4 both idle snz", 32'(pospuesto), 32'h0);
    check("s4 both idle ring", 32'(sonando), 32'h0);
    set_time(10, 40); cyc(2);

    // Disable by write, then re-enable at the current time.
    wr(1, 11, 0, 1);
    set_time(10, 59); cyc(2);
    set_time(11, 0); cyc(2);
    check("s5 ring", 32'(sonando), 32'h2);
    wr(1, 11, 0, 0);
    check("s5 disabled", 32'(sonando), 32'h0);
    wr(1, 11, 0, 1);
    check("s5 rewrite latency", 32'(sonando), 32'h0);
    cyc(1);
    check("s5 rewrite ring", 32'(sonando), 32'h2);

    // Reset during ring and snooze.
    wr(2, 11, 0, 1); cyc(1);
    check("s6 ch1 ch2 ring", 32'(sonando), 32'h6);
    pulse_pos();
    check("s6 snoozed", 32'(pospuesto), 32'h6);
    wr(0, 11, 0, 1); cyc(1);
    check("s6 ch0 ring", 32'(sonando), 32'h1);
    reset = 1; cyc(1); reset = 0;
    $display("reset");
    check("s6 reset outputs", 32'({sonando, pospuesto, alarma, ledsAl}), 32'h0);
    cyc(5);
    check("s6 old alarm gone", 32'(sonando), 32'h0);
    cyc(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
